// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU-control / branch-resolution stage.
// Holds ALU codes, decode classes, branch func3 values and the decode helper.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_AND     = 4'd2,
        ALU_OR      = 4'd3,
        ALU_XOR     = 4'd4,
        ALU_SLT     = 4'd5,
        ALU_SLTU    = 4'd6,
        ALU_SLL     = 4'd7,
        ALU_SRL     = 4'd8,
        ALU_SRA     = 4'd9,
        ALU_PASSB   = 4'd10,
        ALU_INVALID = 4'd15
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_FUNC = 3'b010,
        OP_MEM  = 3'b011,
        OP_LUI  = 3'b100
    } alu_op_e;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } flush_state_e;

    typedef struct packed {
        alu_ctrl_e ctrl;
        logic      byte_op;
        logic      half_op;
        logic      unsigned_ld;
        logic      illegal;
    } dec_t;

    function automatic dec_t decode(
        input logic [2:0] alu_op,
        input logic [2:0] func3,
        input logic       func7_5,
        input logic       op5
    );
        dec_t d;
        d.ctrl        = ALU_ADD;
        d.byte_op     = 1'b0;
        d.half_op     = 1'b0;
        d.unsigned_ld = 1'b0;
        d.illegal     = 1'b0;
        unique case (1'b1)
            (alu_op == OP_ADD): d.ctrl = ALU_ADD;
            (alu_op == OP_SUB): d.ctrl = ALU_SUB;
            (alu_op == OP_FUNC): begin
                unique case (func3)
                    3'b000: d.ctrl = (op5 & func7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: d.ctrl = ALU_SLL;
                    3'b010: d.ctrl = ALU_SLT;
                    3'b011: d.ctrl = ALU_SLTU;
                    3'b100: d.ctrl = ALU_XOR;
                    3'b101: d.ctrl = func7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: d.ctrl = ALU_OR;
                    3'b111: d.ctrl = ALU_AND;
                endcase
            end
            (alu_op == OP_MEM): begin
                d.ctrl        = ALU_ADD;
                d.byte_op     = (func3[1:0] == 2'b00);
                d.half_op     = (func3[1:0] == 2'b01);
                d.unsigned_ld = func3[2];
            end
            (alu_op == OP_LUI): d.ctrl = ALU_PASSB;
            default: begin
                d.ctrl    = ALU_INVALID;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation plus the redirect pulse and flush window.
// Resolutions arriving during the flush window belong to squashed work.
module branch_resolve
    import alu_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic       res_branch,
    input  logic       res_jlink,
    input  logic [2:0] res_func3,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_v,
    input  logic       flag_c,
    output logic       pc_src_o,
    output logic       flush_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    flush_state_e     state;
    flush_state_e     state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             pc_src_nx;
    logic             cond;
    logic             lt;
    logic             taken;

    assign lt = flag_n ^ flag_v;

    always_comb begin
        cond = 1'b0;
        unique case (res_func3)
            BR_EQ:   cond = flag_z;
            BR_NE:   cond = !flag_z;
            BR_LT:   cond = lt;
            BR_GE:   cond = !lt;
            BR_LTU:  cond = !flag_c;
            BR_GEU:  cond = flag_c;
            default: cond = 1'b0;
        endcase
    end

    assign taken = res_valid & (res_jlink | (res_branch & cond));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pc_src_o <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pc_src_o <= pc_src_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        pc_src_nx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (taken) begin
                    state_nx  = ST_FLUSH;
                    cnt_nx    = CNT_LOAD;
                    pc_src_nx = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt == '0) state_nx = ST_IDLE;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
        endcase
    end

    always_comb begin
        flush_o = (state == ST_FLUSH);
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control decode between ID and EX with valid/ready handshake.
// Also hosts branch resolution; an active flush squashes the pipeline register.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        func3,
    input  logic              func7_5,
    input  logic              op5,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              byte_op_o,
    output logic              half_op_o,
    output logic              unsigned_ld_o,
    output logic              illegal_o,
    input  logic              res_valid,
    input  logic              res_branch,
    input  logic              res_jlink,
    input  logic [2:0]        res_func3,
    input  logic              flag_z,
    input  logic              flag_n,
    input  logic              flag_v,
    input  logic              flag_c,
    output logic              pc_src_o,
    output logic              flush_o
);

    dec_t dec;
    dec_t q;

    assign in_ready = !out_valid | out_ready;
    assign dec      = decode(alu_op, func3, func7_5, op5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush_o) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            q         <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign alu_ctrl_o    = CTRL_W'(q.ctrl);
    assign byte_op_o     = q.byte_op;
    assign half_op_o     = q.half_op;
    assign unsigned_ld_o = q.unsigned_ld;
    assign illegal_o     = q.illegal;

    branch_resolve #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_br (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_branch(res_branch),
        .res_jlink (res_jlink),
        .res_func3 (res_func3),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_c    (flag_c),
        .pc_src_o  (pc_src_o),
        .flush_o   (flush_o)
    );

endmodule
